fifox_multi_rd: RTL and testbench

FIFOX_MULTI_RD -- requirements
Module: fifox_multi_rd

---
 rtl/fifox_multi_rd_if.sv | 20 ++
 rtl/fifox_multi_rd.sv | 70 +++++++
 tb/tb_fifox_multi_rd.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifox_multi_rd_if.sv
// Bus bundle for fifox_multi_rd: write side, multi-slot read side and status.
// Handshake: a write lands when WR=1 and FULL=0 at a rising CLK edge. A read of slot i lands when RD[0..i] are all 1 and EMPTY[0..i] are all 0 at that edge.
interface fifox_multi_rd_if #(
    parameter int ITEM_WIDTH = 8,
    parameter int ITEMS      = 16,
    parameter int RD_PORTS   = 4
);
    logic [ITEM_WIDTH-1:0]          DI;
    logic                           WR;
    logic                           FULL;
    logic                           AFULL;
    logic [RD_PORTS*ITEM_WIDTH-1:0] DO;
    logic [RD_PORTS-1:0]            RD;
    logic [RD_PORTS-1:0]            EMPTY;
    logic                           AEMPTY;
    logic [$clog2(ITEMS):0]         STATUS;

    modport master (output DI, WR, RD, input FULL, AFULL, DO, EMPTY, AEMPTY, STATUS);
    modport slave  (input DI, WR, RD, output FULL, AFULL, DO, EMPTY, AEMPTY, STATUS);
endinterface

// File: rtl/fifox_multi_rd.sv
// Circular-buffer FIFO with one write per cycle and up to RD_PORTS first-word-fall-through
// reads per cycle; read slots are consumed as a contiguous run starting from slot 0.
module fifox_multi_rd #(
    parameter int ITEM_WIDTH          = 8,
    parameter int ITEMS               = 16,
    parameter int RD_PORTS            = 4,
    parameter int ALMOST_FULL_OFFSET  = 2,
    parameter int ALMOST_EMPTY_OFFSET = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    fifox_multi_rd_if.slave   bus
);
    localparam int PW = $clog2(ITEMS);
    localparam int CW = PW + 1;

    logic [ITEM_WIDTH-1:0] mem [ITEMS];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         rd_num;
    logic                  wr_ok;
    logic                  run;

    assign wr_ok = bus.WR && (count != CW'(ITEMS));

    // Accepted reads stop at the first deasserted RD bit or the first empty slot.
    always_comb begin
        rd_num = '0;
        run    = 1'b1;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (run && bus.RD[i] && (count > CW'(i))) begin
                rd_num = rd_num + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            rd_ptr <= rd_ptr + rd_num[PW-1:0];
            count  <= count + CW'(wr_ok) - rd_num;
        end
    end

    // Storage is not reset; stale contents are hidden by EMPTY.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.DI;
        end
    end

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_slot
        assign bus.DO[g*ITEM_WIDTH +: ITEM_WIDTH] = mem[rd_ptr + PW'(g)];
        assign bus.EMPTY[g] = (count <= CW'(g));
    end

    assign bus.FULL   = (count == CW'(ITEMS));
    assign bus.AFULL  = (count >= CW'(ITEMS - ALMOST_FULL_OFFSET));
    assign bus.AEMPTY = (count <= CW'(ALMOST_EMPTY_OFFSET));
    assign bus.STATUS = count;
endmodule

// File: tb/tb_fifox_multi_rd.sv
// Directed and randomised bench for fifox_multi_rd with a queue model of the stored items.
module tb_fifox_multi_rd;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] exp_q[$];

    fifox_multi_rd_if #(.ITEM_WIDTH(8), .ITEMS(16), .RD_PORTS(4)) bus ();

    fifox_multi_rd #(
        .ITEM_WIDTH(8), .ITEMS(16), .RD_PORTS(4),
        .ALMOST_FULL_OFFSET(2), .ALMOST_EMPTY_OFFSET(2)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        int sz;
        sz = exp_q.size();
        chk("status", 32'(bus.STATUS), 32'(sz));
        chk("full", 32'(bus.FULL), 32'(sz == 16));
        chk("afull", 32'(bus.AFULL), 32'(sz >= 14));
        chk("aempty", 32'(bus.AEMPTY), 32'(sz <= 2));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("empty%0d", i), 32'(bus.EMPTY[i]), 32'(sz <= i));
            if (i < sz) chk($sformatf("slot%0d", i), 32'(bus.DO[i*8 +: 8]), 32'(exp_q[i]));
        end
    endtask

    // Called at a falling edge: drives one request, compares the read-out items, advances the model.
    task automatic cycle(input logic w, input logic [7:0] d, input logic [3:0] r);
        int  n;
        bit  run;
        bit  w_ok;
        bus.WR = w;
        bus.DI = d;
        bus.RD = r;
        #1;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (run && r[i] && (i < exp_q.size())) n++;
            else run = 1'b0;
        end
        for (int i = 0; i < n; i++) chk($sformatf("rd_item%0d", i), 32'(bus.DO[i*8 +: 8]), 32'(exp_q[i]));
        w_ok = w && (exp_q.size() < 16);
        @(posedge clk);
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
        if (w_ok) exp_q.push_back(d);
        @(negedge clk);
        bus.WR = 1'b0;
        bus.RD = '0;
        check_status();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.WR = 1'b0;
        bus.DI = '0;
        bus.RD = '0;
        repeat (2) @(negedge clk);
        check_status();
        rst_n = 1'b1;

        // Three writes, no reads.
        for (int k = 1; k <= 3; k++) cycle(1'b1, 8'(k), 4'b0000);
        chk("req31_status", 32'(bus.STATUS), 32'd3);
        chk("req31_empty", 32'(bus.EMPTY), 32'b1000);

        // Multi-read of three items.
        for (int k = 4; k <= 6; k++) cycle(1'b1, 8'(k), 4'b0000);
        cycle(1'b0, 8'h00, 4'b0111);
        chk("req32_slot0", 32'(bus.DO[7:0]), 32'h04);

        // Non-contiguous and over-read requests.
        cycle(1'b0, 8'h00, 4'b0001);
        cycle(1'b0, 8'h00, 4'b1101);
        chk("req33_status1", 32'(bus.STATUS), 32'd1);
        cycle(1'b1, 8'h07, 4'b0000);
        cycle(1'b0, 8'h00, 4'b1111);
        chk("req33_empty", 32'(bus.EMPTY), 32'b1111);

        // Fill, then write while full with a read, then write+read.
        for (int k = 0; k < 16; k++) cycle(1'b1, 8'(8'h10 + k), 4'b0000);
        chk("req34_full", 32'(bus.FULL), 32'd1);
        cycle(1'b1, 8'hEE, 4'b0001);
        chk("req34_status15", 32'(bus.STATUS), 32'd15);
        cycle(1'b1, 8'hEF, 4'b0011);
        chk("req34_status14", 32'(bus.STATUS), 32'd14);
        for (int k = 0; k < 6 && exp_q.size() > 0; k++) cycle(1'b0, 8'h00, 4'b1111);

        // Wrap-around stream with interleaved reads.
        for (int k = 1; k <= 30; k++) begin
            if (k % 3 == 0) cycle(1'b1, 8'(k), 4'b1111);
            else cycle(1'b1, 8'(k), 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) cycle(1'b0, 8'h00, 4'($urandom_range(0, 15)) | 4'b0001);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Random mixed traffic.
        for (int k = 0; k < 200; k++) cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));

        // Reset between clock edges with items stored.
        for (int k = 0; k < 6 && exp_q.size() > 0; k++) cycle(1'b0, 8'h00, 4'b1111);
        for (int k = 0; k < 10; k++) cycle(1'b1, 8'(8'hA0 + k), 4'b0000);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_status();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h5A, 4'b0000);
        cycle(1'b0, 8'h00, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
